// File: rtl/minbd_pkg.sv
// Shared MinBD router definitions: flit width, slot indices, route codes.
package minbd_pkg;

    localparam int FLIT_W = 11;

    localparam logic [1:0] SLOT_N = 2'd0;
    localparam logic [1:0] SLOT_S = 2'd1;
    localparam logic [1:0] SLOT_E = 2'd2;
    localparam logic [1:0] SLOT_W = 2'd3;

    localparam logic [2:0] RC_EAST  = 3'b000;
    localparam logic [2:0] RC_WEST  = 3'b001;
    localparam logic [2:0] RC_NORTH = 3'b010;
    localparam logic [2:0] RC_SOUTH = 3'b011;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/sb_fifo.sv
// Side-buffer FIFO: registered storage, head read combinationally from the read pointer.
module sb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/buff_reinject.sv
// MinBD side-buffer store and re-injection into empty N/S/E/W slots.
// Define BUFF_REINJECT_RR_EN for round-robin slot search; default is fixed N>S>E>W.
module buff_reinject
    import minbd_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = minbd_pkg::FLIT_W,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] sb_flit,
    input  logic              sb_valid,
    output logic              sb_ready,
    input  logic [FLIT_W-1:0] n_in,
    input  logic [FLIT_W-1:0] s_in,
    input  logic [FLIT_W-1:0] e_in,
    input  logic [FLIT_W-1:0] w_in,
    input  logic              n_vld,
    input  logic              s_vld,
    input  logic              e_vld,
    input  logic              w_vld,
    output logic [FLIT_W-1:0] n_out,
    output logic [FLIT_W-1:0] s_out,
    output logic [FLIT_W-1:0] e_out,
    output logic [FLIT_W-1:0] w_out,
    output logic              n_ovld,
    output logic              s_ovld,
    output logic              e_ovld,
    output logic              w_ovld,
    output logic [CW-1:0]     sb_count,
    output logic              inj_fire
);

    // Handshake: a flit transfers on a clk edge where sb_valid && sb_ready;
    // sb_ready depends only on registered occupancy, never on sb_valid.
    logic [FLIT_W-1:0] slot_in [4];
    logic [FLIT_W-1:0] slot_q  [4];
    logic [3:0]        vld;
    logic [3:0]        ovld_q;
    logic [FLIT_W-1:0] head;
    logic              full;
    logic              empty;
    logic              pop;
    logic [1:0]        sel;

    assign slot_in[SLOT_N] = n_in;
    assign slot_in[SLOT_S] = s_in;
    assign slot_in[SLOT_E] = e_in;
    assign slot_in[SLOT_W] = w_in;
    assign vld = {w_vld, e_vld, s_vld, n_vld};

    assign sb_ready = !full;
    assign pop      = !empty && (vld != 4'hF);

    sb_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sb_valid && sb_ready),
        .din   (sb_flit),
        .pop   (pop),
        .dout  (head),
        .count (sb_count),
        .full  (full),
        .empty (empty)
    );

`ifdef BUFF_REINJECT_RR_EN
    logic [1:0] rr_ptr;

    always_comb begin
        logic       found;
        logic [1:0] idx;
        sel   = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && !vld[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rr_ptr <= SLOT_N;
        else if (pop) rr_ptr <= sel + 2'd1;
    end
`else
    // Scan from W down to N so the lowest-numbered empty slot wins.
    always_comb begin
        sel = SLOT_N;
        for (int k = 3; k >= 0; k--) begin
            if (!vld[k]) sel = 2'(k);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            ovld_q   <= '0;
            inj_fire <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (vld[i])                   slot_q[i] <= slot_in[i];
                else if (pop && sel == 2'(i)) slot_q[i] <= head;
                else                          slot_q[i] <= '0;
                ovld_q[i] <= vld[i] || (pop && sel == 2'(i));
            end
            inj_fire <= pop;
        end
    end

    assign n_out  = slot_q[SLOT_N];
    assign s_out  = slot_q[SLOT_S];
    assign e_out  = slot_q[SLOT_E];
    assign w_out  = slot_q[SLOT_W];
    assign n_ovld = ovld_q[SLOT_N];
    assign s_ovld = ovld_q[SLOT_S];
    assign e_ovld = ovld_q[SLOT_E];
    assign w_ovld = ovld_q[SLOT_W];

endmodule

// File: tb/tb_buff_reinject.sv
// Directed bench for buff_reinject; expectations follow BUFF_REINJECT_RR_EN when defined.
module tb_buff_reinject;

  logic        clk;
  logic        rst_n;
  logic [10:0] sb_flit;
  logic        sb_valid;
  logic        sb_ready;
  logic [10:0] n_in, s_in, e_in, w_in;
  logic        n_vld, s_vld, e_vld, w_vld;
  logic [10:0] n_out, s_out, e_out, w_out;
  logic        n_ovld, s_ovld, e_ovld, w_ovld;
  logic [2:0]  sb_count;
  logic        inj_fire;
  logic [3:0]  ovld4;
  logic [10:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  assign ovld4 = {w_ovld, e_ovld, s_ovld, n_ovld};

  buff_reinject #(.DEPTH(4), .FLIT_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .sb_flit(sb_flit), .sb_valid(sb_valid), .sb_ready(sb_ready),
    .n_in(n_in), .s_in(s_in), .e_in(e_in), .w_in(w_in),
    .n_vld(n_vld), .s_vld(s_vld), .e_vld(e_vld), .w_vld(w_vld),
    .n_out(n_out), .s_out(s_out), .e_out(e_out), .w_out(w_out),
    .n_ovld(n_ovld), .s_ovld(s_ovld), .e_ovld(e_ovld), .w_ovld(w_ovld),
    .sb_count(sb_count), .inj_fire(inj_fire)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // drivers
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_slots(input logic [3:0] v, input logic [10:0] fn, input logic [10:0] fs,
                           input logic [10:0] fe, input logic [10:0] fw);
    {w_vld, e_vld, s_vld, n_vld} = v;
    n_in = fn; s_in = fs; e_in = fe; w_in = fw;
  endtask

  task automatic apply_reset;
    sb_valid = 1'b0;
    sb_flit  = '0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sb_valid = 1'b1;
    sb_flit = 11'h3AA;
    set_slots(4'hF, 11'h011, 11'h022, 11'h033, 11'h044);
    repeat (2) tick();
    n_cmp++; if (ovld4 !== 4'h0) begin n_err++; $display("FAIL reset_ovld: got %b expected 0000", ovld4); end
    n_cmp++; if ({n_out, s_out, e_out, w_out} !== 44'h0) begin n_err++; $display("FAIL reset_out: got %h %h %h %h expected 0", n_out, s_out, e_out, w_out); end
    n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", sb_count); end
    n_cmp++; if (sb_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", sb_ready); end
    n_cmp++; if (inj_fire !== 1'b0) begin n_err++; $display("FAIL reset_inj: got %b expected 0", inj_fire); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL reset_first_push: got %0d expected 1", sb_count); end
    n_cmp++; if (n_out !== 11'h011 || ovld4 !== 4'hF) begin n_err++; $display("FAIL reset_passthru: got %h/%b expected 011/1111", n_out, ovld4); end
    sb_valid = 1'b0;
    set_slots(4'h0, '0, '0, '0, '0);
    tick();
    n_cmp++; if (n_out !== 11'h3AA || ovld4 !== 4'b0001 || inj_fire !== 1'b1) begin n_err++; $display("FAIL reset_drain: got %h/%b/%b expected 3aa/0001/1", n_out, ovld4, inj_fire); end
  endtask

  task automatic test_push_inject;
    apply_reset();
    set_slots(4'h0, '0, '0, '0, '0);
    sb_valid = 1'b1;
    sb_flit = 11'h155;
    tick();
    sb_valid = 1'b0;
    n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL push_count: got %0d expected 1", sb_count); end
    n_cmp++; if (inj_fire !== 1'b0 || ovld4 !== 4'h0) begin n_err++; $display("FAIL push_no_bypass: got inj %b ovld %b expected 0/0000", inj_fire, ovld4); end
    tick();
    n_cmp++; if (n_out !== 11'h155 || n_ovld !== 1'b1) begin n_err++; $display("FAIL inject_n: got %h/%b expected 155/1", n_out, n_ovld); end
    n_cmp++; if (inj_fire !== 1'b1 || sb_count !== 3'd0) begin n_err++; $display("FAIL inject_fire: got %b cnt %0d expected 1/0", inj_fire, sb_count); end
  endtask

  task automatic test_first_empty;
    apply_reset();
    set_slots(4'b0011, 11'h011, 11'h022, '0, '0);
    sb_valid = 1'b1;
    sb_flit = 11'h0A1;
    tick();
    sb_valid = 1'b0;
    n_cmp++; if (sb_count !== 3'd1 || e_ovld !== 1'b0) begin n_err++; $display("FAIL first_empty_push: got cnt %0d e_ovld %b expected 1/0", sb_count, e_ovld); end
    tick();
    n_cmp++; if (n_out !== 11'h011 || s_out !== 11'h022) begin n_err++; $display("FAIL first_empty_pass: got %h %h expected 011 022", n_out, s_out); end
    n_cmp++; if (e_out !== 11'h0A1 || e_ovld !== 1'b1) begin n_err++; $display("FAIL first_empty_e: got %h/%b expected 0a1/1", e_out, e_ovld); end
    n_cmp++; if (w_ovld !== 1'b0 || w_out !== 11'h000) begin n_err++; $display("FAIL first_empty_w: got %h/%b expected 000/0", w_out, w_ovld); end
  endtask

  task automatic test_full;
    apply_reset();
    set_slots(4'hF, 11'h001, 11'h002, 11'h003, 11'h004);
    for (int i = 0; i < 4; i++) begin
      sb_valid = 1'b1;
      sb_flit = 11'h101 + 11'(i);
      exp_q.push_back(sb_flit);
      tick();
    end
    n_cmp++; if (sb_count !== 3'd4 || sb_ready !== 1'b0) begin n_err++; $display("FAIL full_state: got cnt %0d ready %b expected 4/0", sb_count, sb_ready); end
    sb_flit = 11'h7FF;
    tick();
    n_cmp++; if (sb_count !== 3'd4 || inj_fire !== 1'b0) begin n_err++; $display("FAIL full_ignore: got cnt %0d inj %b expected 4/0", sb_count, inj_fire); end
    // push while full with a pop in the same cycle must still be refused
    sb_flit = 11'h7FE;
    w_vld = 1'b0;
    tick();
    sb_valid = 1'b0;
    n_cmp++; if (w_out !== exp_q.pop_front() || w_ovld !== 1'b1 || inj_fire !== 1'b1) begin n_err++; $display("FAIL full_free_w: got %h/%b/%b expected 101/1/1", w_out, w_ovld, inj_fire); end
    n_cmp++; if (sb_count !== 3'd3 || sb_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_rise: got cnt %0d ready %b expected 3/1", sb_count, sb_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (w_out !== exp_q[0] || sb_count !== 3'(2 - i)) begin n_err++; $display("FAIL full_drain%0d: got %h cnt %0d expected %h cnt %0d", i, w_out, sb_count, exp_q[0], 2 - i); end
      void'(exp_q.pop_front());
    end
    tick();
    n_cmp++; if (inj_fire !== 1'b0 || w_ovld !== 1'b0 || sb_count !== 3'd0) begin n_err++; $display("FAIL full_no_extra: got inj %b w_ovld %b cnt %0d expected 0/0/0", inj_fire, w_ovld, sb_count); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    set_slots(4'hF, 11'h001, 11'h002, 11'h003, 11'h004);
    for (int i = 0; i < 2; i++) begin
      sb_valid = 1'b1;
      sb_flit = 11'h600 + 11'(i);
      exp_q.push_back(sb_flit);
      tick();
    end
    n_cmp++; if (sb_count !== 3'd2) begin n_err++; $display("FAIL b2b_prefill: got %0d expected 2", sb_count); end
    n_vld = 1'b0;
    for (int i = 2; i < 8; i++) begin
      sb_flit = 11'h600 + 11'(i);
      exp_q.push_back(sb_flit);
      tick();
      n_cmp++; if (n_out !== exp_q[0] || n_ovld !== 1'b1 || sb_count !== 3'd2) begin n_err++; $display("FAIL b2b_step%0d: got %h/%b cnt %0d expected %h/1 cnt 2", i, n_out, n_ovld, sb_count, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    sb_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (n_out !== exp_q[0] || sb_count !== 3'(1 - i)) begin n_err++; $display("FAIL b2b_drain%0d: got %h cnt %0d expected %h cnt %0d", i, n_out, sb_count, exp_q[0], 1 - i); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_slot_order;
    logic [1:0]  slot;
    logic [10:0] got;
    apply_reset();
    set_slots(4'hF, 11'h001, 11'h002, 11'h003, 11'h004);
    for (int i = 0; i < 4; i++) begin
      sb_valid = 1'b1;
      sb_flit = 11'h2C0 + 11'(i);
      exp_q.push_back(sb_flit);
      tick();
    end
    sb_valid = 1'b0;
    set_slots(4'h0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef BUFF_REINJECT_RR_EN
      slot = 2'(i);
`else
      slot = 2'd0;
`endif
      case (slot)
        2'd0: got = n_out;
        2'd1: got = s_out;
        2'd2: got = e_out;
        default: got = w_out;
      endcase
      n_cmp++; if (ovld4 !== (4'b0001 << slot) || got !== exp_q[0]) begin n_err++; $display("FAIL order%0d: got ovld %b flit %h expected ovld %b flit %h", i, ovld4, got, 4'b0001 << slot, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sb_valid = 1'b0;
    sb_flit = '0;
    set_slots(4'h0, '0, '0, '0, '0);
    test_reset();
    test_push_inject();
    test_first_empty();
    test_full();
    test_back_to_back();
    test_slot_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
